// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_clock_ctrl_pkg
// Shared definitions for the CPU clock-enable controller: FSM state
// encodings and the mode-select constants.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP_ARM = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/cpu_clock_ctrl_button_sync.sv
// button_sync
// Conditions the raw single-step push-button: 2-flop synchronizer, rising-
// edge detect and a tick-based lockout so that contact bounce yields exactly
// one pulse per press.
// Ports:
//   clk    - board clock
//   reset  - asynchronous, active-high
//   tick   - one-clk pulse from the slow clock divider
//   btn    - raw asynchronous button level
//   pulse  - one-clk registered pulse per accepted press
module button_sync #(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic pulse
);

  localparam int DB_W = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS);

  logic            sync1;
  logic            sync2;
  logic            sync_q;
  logic            locked;
  logic [DB_W-1:0] db_cnt;
  logic            rise;
  logic            accept;

  assign rise   = sync2 & ~sync_q;
  assign accept = rise & ~locked;

  // After an accepted press the detector stays locked until the synchronized
  // level has read low on DB_TICKS consecutive ticks; any tick that sees the
  // level high restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_q <= 1'b0;
      pulse  <= 1'b0;
      locked <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      sync_q <= sync2;
      pulse  <= accept;
      if (accept) begin
        locked <= 1'b1;
        db_cnt <= '0;
      end else if (tick) begin
        if (sync2) begin
          db_cnt <= '0;
        end else if (locked) begin
          if (db_cnt == DB_W'(DB_TICKS - 1)) begin
            locked <= 1'b0;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
// Run/step/halt controller for the processor clock-enable. Turns the slow
// divider tick into the cpu_en pulse that gates the datapath registers.
// Ports:
//   clk       - board clock
//   reset     - asynchronous, active-high
//   tick      - one-clk pulse from the slow clock divider
//   mode      - 00 HALT, 01 RUN, 10 STEP, 11 HALT
//   step_btn  - raw single-step push-button
//   resume    - level, starts RUN when mode is RUN
//   halt_req  - one-clk halt pulse from the CPU
//   cpu_en    - datapath enable, combinational, aligned with tick
//   running   - high while in RUN
//   step_busy - high while a step is armed
//   en_count  - number of cpu_en pulses issued, wraps
//
// state    | meaning
// ST_IDLE  | no enables issued, waiting for resume or a step press
// ST_RUN   | every tick becomes a cpu_en
// ST_STEP_ARM | next tick becomes one cpu_en, then back to idle
module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int DB_TICKS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             resume,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             step_busy,
  output logic [CNT_W-1:0] en_count
);

  state_t state;
  state_t state_nxt;
  logic   step_pulse;

  button_sync #(
    .DB_TICKS (DB_TICKS)
  ) u_button_sync (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // No register stage so the enable lines up with the divider tick. The
  // exit conditions are folded in so an exiting cycle never pulses, and
  // reset gates it so it drops the moment reset asserts.
  always_comb begin
    cpu_en = 1'b0;
    if (!reset && !halt_req) begin
      case (state)
        ST_RUN:      cpu_en = tick && (mode == MODE_RUN);
        ST_STEP_ARM: cpu_en = tick && (mode == MODE_STEP);
        default:     cpu_en = 1'b0;
      endcase
    end
  end

  // halt_req outranks a mode change, which outranks tick / step_pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (halt_req)
          state_nxt = ST_IDLE;
        else if ((mode == MODE_RUN) && resume)
          state_nxt = ST_RUN;
        else if ((mode == MODE_STEP) && step_pulse)
          state_nxt = ST_STEP_ARM;
      end
      ST_RUN: begin
        if (halt_req || (mode != MODE_RUN))
          state_nxt = ST_IDLE;
      end
      ST_STEP_ARM: begin
        if (halt_req || (mode != MODE_STEP))
          state_nxt = ST_IDLE;
        else if (tick)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they track the state
  // register without an extra cycle of lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= (state_nxt == ST_RUN);
      step_busy <= (state_nxt == ST_STEP_ARM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      en_count <= '0;
    else if (cpu_en)
      en_count <= en_count + 1'b1;
  end

endmodule
